contador_transiciones: RTL and testbench
========================================

// Module: contador_transiciones
// PURPOSE
//  Upstream feeder of the transition-counter memory (dir/LE/dato port).
//  Watches NUM_SIG monitored signals, detects every 0->1 and 1->0 toggle and
//  accumulates toggles in small per-signal pending counters. Commits them to
//  memory entry i via read-modify-write: LE=1 to read, then LE=0 to write.
//  Clears all memory entries after reset, since the memory itself has no reset.
// PARAMETERS
//  NUM_SIG  5   monitored signals = memory entries used (entries 0..NUM_SIG-1)
//  DIR_W    4   memory address width; 2**DIR_W must be > NUM_SIG
//  DATA_W   32  counter / data bus width
//  PEND_W   4   width of each per-signal pending toggle counter
// PORTS
//  clk        in     1        single clock, rising edge
//  reset_L    in     1        synchronous reset, active low
//  en         in     1        1: toggles are counted; 0: toggles ignored
//  pausa      in     1        request to stop committing and release the bus
//  sig        in     NUM_SIG  monitored signals, synchronous to clk
//  dir        out    DIR_W    memory address
//  LE         out    1        1 = read (memory drives dato); 0 = write
//  dato       inout  DATA_W   driven by this block only while LE=0, else Z
//  bus_libre  out    1        1: idle and paused; external reader may own the bus
//  init_done  out    1        memory clear finished
//  ovf        out    1        sticky: a pending counter saturated and lost toggles
// BEHAVIOUR
//  Reset (reset_L=0 at a clk edge): dir=0, LE=1, dato=Z, bus_libre=0,
//   init_done=0, ovf=0, all pending=0, sig_q<=sig, state=INIT, k=0.
//  Toggle detect: tog=sig^sig_q at each edge; sig_q<=sig. If en=1, pending[j]+=tog[j],
//   saturating at 2**PEND_W-1; saturation with tog[j]=1 sets ovf.
//   Toggle detection and pending accumulation run in every state, including INIT.
//  FSM states: INIT, IDLE, RD, WR.
//  INIT: each cycle LE=0, dir=k, dato=0; k++. After k=NUM_SIG-1: init_done=1 -> IDLE.
//   Takes exactly NUM_SIG cycles. pausa is ignored during INIT.
//  IDLE: LE=1, dato=Z.
//   If pausa=1: stay, bus_libre=1.
//   Else if any pending!=0: choose i round-robin, starting after the last
//    serviced index and wrapping NUM_SIG-1 -> 0; go to RD.
//   Else stay.
//  RD (1 cycle): dir=i, LE=1. At the edge: rd_q<=dato, snap<=pending[i].
//   Same edge: pending[i]<=pending[i]-pending[i]+tog[i], i.e. only a toggle arriving
//   that cycle stays pending. -> WR.
//  WR (1 cycle): dir=i, LE=0, dato=rd_q+snap, saturating at 2**DATA_W-1 (no wrap).
//   -> IDLE. dir/dato are stable for the whole LE=0 cycle.
//  Each commit takes 3 cycles (IDLE, RD, WR). No pending toggle is ever lost unless ovf=1.
//  pausa during RD/WR: the current commit completes; the FSM then holds in IDLE.
//  bus_libre is a registered output; it is 1 from the first IDLE cycle with pausa=1.
//  Reset mid-operation: immediate return to the reset state on the next edge.
//   Any partial write is overwritten by INIT.
//  dato is never driven while LE=1, so there is no bus contention with the memory read.
// TESTING
//  T1 reset, memory preloaded with 32'hDEAD_BEEF -> 5 INIT cycles;
//     all entries 0; init_done=1 on cycle 6.
//  T2 en=1, one pulse on sig[2] (2 toggles) -> entry 2 reads 2; others 0.
//  T3 sig[0] and sig[4] toggle on the same cycle -> serviced 0 then 4 (round-robin);
//     each entry reads 1.
//  T4 entry 1 preloaded 32'hFFFF_FFFE, 3 toggles -> entry reads 32'hFFFF_FFFF (saturate).
//  T5 16 toggles on sig[3] within 16 cycles with pausa=1 -> pending saturates at 15,
//     ovf=1; after pausa=0 the entry reads 15.
//  T6 pausa raised in RD -> the WR completes, bus_libre=1 in the next IDLE.
//     A toggle arriving in RD is committed after pausa=0.

Source files
------------

// File: rtl/contador_transiciones_if.sv
// Control, status and memory-address signals of the transition counter.
// master = contador_transiciones, slave = the surrounding system / bench.
interface contador_transiciones_if #(
    parameter int NUM_SIG = 5,
    parameter int DIR_W   = 4
);
    // Memory port protocol: LE=1 means the memory drives dato with entry dir
    // (read); LE=0 means this block drives dato and the memory stores it at
    // the next rising edge (write). dir and dato are stable over each LE=0 cycle.
    logic               en;
    logic               pausa;
    logic [NUM_SIG-1:0] sig;
    logic [DIR_W-1:0]   dir;
    logic               LE;
    logic               bus_libre;
    logic               init_done;
    logic               ovf;
    logic [1:0]         state_dbg;

    modport master (
        input  en, pausa, sig,
        output dir, LE, bus_libre, init_done, ovf, state_dbg
    );

    modport slave (
        output en, pausa, sig,
        input  dir, LE, bus_libre, init_done, ovf, state_dbg
    );
endinterface

// File: rtl/contador_transiciones.sv
// Toggle counter feeder: accumulates per-signal toggles and commits them to an
// external counter memory by read-modify-write; clears the memory after reset.
module contador_transiciones #(
    parameter int NUM_SIG = 5,
    parameter int DIR_W   = 4,
    parameter int DATA_W  = 32,
    parameter int PEND_W  = 4
) (
    input  logic                   clk,
    input  logic                   reset_L,
    contador_transiciones_if.master bus,
    inout  wire  [DATA_W-1:0]      dato
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RD   = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    state_t              state, state_next;
    logic [DIR_W-1:0]    k;
    logic [DIR_W-1:0]    cur;
    logic [DIR_W-1:0]    last;
    logic [DIR_W-1:0]    dir_r;
    logic                le_r;
    logic                init_r;
    logic                libre_r;
    logic                ovf_r;
    logic [NUM_SIG-1:0]  sig_q;
    logic [NUM_SIG-1:0]  tog;
    logic [PEND_W-1:0]   pending   [NUM_SIG];
    logic [PEND_W-1:0]   pend_next [NUM_SIG];
    logic                pend_sat;
    logic [PEND_W-1:0]   base;
    logic [DATA_W-1:0]   rd_q;
    logic [PEND_W-1:0]   snap;
    logic [PEND_W-1:0]   snap_sel;
    logic [DIR_W-1:0]    pick_hi, pick_lo, pick;
    logic                found_hi, found_lo, found;
    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   wdata;

    assign tog = bus.sig ^ sig_q;

    // Round-robin: first pending index above the last serviced one, else wrap.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int j = 0; j < NUM_SIG; j++) begin
            if (pending[j] != '0) begin
                if (DIR_W'(j) > last) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        pick_hi  = DIR_W'(j);
                    end
                end else if (!found_lo) begin
                    found_lo = 1'b1;
                    pick_lo  = DIR_W'(j);
                end
            end
        end
        found = found_hi | found_lo;
        pick  = found_hi ? pick_hi : pick_lo;
    end

    always_comb begin
        snap_sel = '0;
        for (int j = 0; j < NUM_SIG; j++) begin
            if (cur == DIR_W'(j)) snap_sel = pending[j];
        end
    end

    // The entry being read hands its count to snap; only a same-cycle toggle stays.
    always_comb begin
        pend_sat = 1'b0;
        base     = '0;
        for (int j = 0; j < NUM_SIG; j++) begin
            base = (state == ST_RD && cur == DIR_W'(j)) ? '0 : pending[j];
            pend_next[j] = base;
            if (bus.en && tog[j]) begin
                if (base == '1) pend_sat = 1'b1;
                else            pend_next[j] = base + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (k == DIR_W'(NUM_SIG)) state_next = ST_IDLE;
            ST_IDLE: if (!bus.pausa && found) state_next = ST_RD;
            ST_RD:   state_next = ST_WR;
            ST_WR:   state_next = ST_IDLE;
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state   <= ST_INIT;
            k       <= '0;
            cur     <= '0;
            last    <= DIR_W'(NUM_SIG - 1);
            dir_r   <= '0;
            le_r    <= 1'b1;
            init_r  <= 1'b0;
            libre_r <= 1'b0;
            ovf_r   <= 1'b0;
            sig_q   <= bus.sig;
            rd_q    <= '0;
            snap    <= '0;
            for (int j = 0; j < NUM_SIG; j++) pending[j] <= '0;
        end else begin
            state   <= state_next;
            sig_q   <= bus.sig;
            for (int j = 0; j < NUM_SIG; j++) pending[j] <= pend_next[j];
            if (pend_sat) ovf_r <= 1'b1;
            libre_r <= (state != ST_INIT) && (state_next == ST_IDLE) && bus.pausa;
            case (state)
                ST_INIT: begin
                    if (k == DIR_W'(NUM_SIG)) begin
                        le_r   <= 1'b1;
                        init_r <= 1'b1;
                    end else begin
                        le_r  <= 1'b0;
                        dir_r <= k;
                        k     <= k + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (state_next == ST_RD) begin
                        cur   <= pick;
                        dir_r <= pick;
                    end
                end
                ST_RD: begin
                    rd_q <= dato;
                    snap <= snap_sel;
                    le_r <= 1'b0;
                end
                ST_WR: begin
                    le_r <= 1'b1;
                    last <= cur;
                end
                default: le_r <= 1'b1;
            endcase
        end
    end

    // Committed value saturates instead of wrapping; INIT writes zeros.
    assign sum   = {1'b0, rd_q} + {{(DATA_W + 1 - PEND_W){1'b0}}, snap};
    assign wdata = (state == ST_WR) ? (sum[DATA_W] ? '1 : sum[DATA_W-1:0]) : '0;
    assign dato  = le_r ? {DATA_W{1'bz}} : wdata;

    assign bus.dir       = dir_r;
    assign bus.LE        = le_r;
    assign bus.bus_libre = libre_r;
    assign bus.init_done = init_r;
    assign bus.ovf       = ovf_r;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_contador_transiciones.sv
// Bench for contador_transiciones: behavioural counter memory on dir/LE/dato,
// expected-write queue checked by a negedge monitor, plus directed status checks.
module tb_contador_transiciones;

    localparam int NUM_SIG = 5;
    localparam int DIR_W   = 4;
    localparam int DATA_W  = 32;
    localparam int PEND_W  = 4;

    logic clk = 1'b0;
    logic reset_L;
    wire  [DATA_W-1:0] dato;

    contador_transiciones_if #(.NUM_SIG(NUM_SIG), .DIR_W(DIR_W)) bus ();

    contador_transiciones #(
        .NUM_SIG(NUM_SIG), .DIR_W(DIR_W), .DATA_W(DATA_W), .PEND_W(PEND_W)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus),
        .dato    (dato)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- counter memory model ----------------
    logic [DATA_W-1:0] mem [16];
    logic              pre_en;
    logic [DIR_W-1:0]  pre_addr;
    logic [DATA_W-1:0] pre_val;

    assign dato = bus.LE ? mem[bus.dir] : {DATA_W{1'bz}};

    always @(posedge clk) begin
        if (pre_en)              mem[pre_addr] <= pre_val;
        else if (bus.LE == 1'b0) mem[bus.dir]  <= dato;
    end

    // ---------------- scoreboard ----------------
    logic [DIR_W+DATA_W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;

    always @(negedge clk) begin
        logic [DIR_W+DATA_W-1:0] e;
        if (mon_on && reset_L && bus.LE == 1'b0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected: got dir=%0d dato=%h, expected no write", bus.dir, dato);
            end else begin
                e = exp_q.pop_front();
                if ({bus.dir, dato} !== e) begin
                    bad++;
                    $display("FAIL write: got dir=%0d dato=%h, expected dir=%0d dato=%h",
                             bus.dir, dato, e[DIR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [DIR_W-1:0] a, input logic [DATA_W-1:0] v);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_val  = v;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    task automatic push_wr(input int a, input logic [DATA_W-1:0] v);
        exp_q.push_back({DIR_W'(a), v});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        int cyc;
        @(negedge clk);
        reset_L = 1'b0;
        wait_cycles(2);
        mon_on = 1'b1;
        check("rst_LE", bus.LE, 1);
        check("rst_dir", bus.dir, 0);
        check("rst_init_done", bus.init_done, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_bus_libre", bus.bus_libre, 0);
        for (int a = 0; a < NUM_SIG; a++) push_wr(a, '0);
        reset_L = 1'b1;
        cyc = 0;
        while (!bus.init_done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("init_cycles", cyc, 6);
        check("init_LE", bus.LE, 1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        reset_L   = 1'b0;
        bus.en    = 1'b0;
        bus.pausa = 1'b0;
        bus.sig   = '0;
        pre_en    = 1'b0;
        pre_addr  = '0;
        pre_val   = '0;
        wait_cycles(2);

        // T1: memory full of garbage, INIT clears entries 0..4
        for (int a = 0; a < NUM_SIG; a++) preload(DIR_W'(a), 32'hDEAD_BEEF);
        do_reset();
        wait_cycles(3);
        for (int a = 0; a < NUM_SIG; a++) check($sformatf("t1_mem%0d", a), mem[a], 0);
        check("t1_q_empty", exp_q.size(), 0);

        // T2: one pulse on sig[2] = two toggles, committed together
        @(negedge clk);
        bus.en = 1'b1;
        push_wr(2, 32'd2);
        @(negedge clk);
        bus.sig[2] = 1'b1;
        @(negedge clk);
        bus.sig[2] = 1'b0;
        wait_cycles(8);
        check("t2_mem2", mem[2], 2);
        check("t2_mem0", mem[0], 0);
        check("t2_mem4", mem[4], 0);
        check("t2_q_empty", exp_q.size(), 0);

        // T3: simultaneous toggles on 0 and 4, serviced 0 then 4
        do_reset();
        push_wr(0, 32'd1);
        push_wr(4, 32'd1);
        @(negedge clk);
        bus.sig[0] = 1'b1;
        bus.sig[4] = 1'b1;
        wait_cycles(10);
        check("t3_mem0", mem[0], 1);
        check("t3_mem4", mem[4], 1);
        check("t3_q_empty", exp_q.size(), 0);

        // T4: saturating commit near the top of the counter range
        do_reset();
        preload(1, 32'hFFFF_FFFE);
        push_wr(1, 32'hFFFF_FFFF);
        push_wr(1, 32'hFFFF_FFFF);
        @(negedge clk); bus.sig[1] = 1'b1;
        @(negedge clk); bus.sig[1] = 1'b0;
        @(negedge clk); bus.sig[1] = 1'b1;
        wait_cycles(10);
        check("t4_mem1", mem[1], 32'hFFFF_FFFF);
        check("t4_q_empty", exp_q.size(), 0);

        // T5: 16 toggles while paused: pending sticks at 15, ovf set
        do_reset();
        @(negedge clk);
        bus.pausa = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1)  check("t5_bus_libre", bus.bus_libre, 1);
            if (i == 16) check("t5_ovf_at_15", bus.ovf, 0);
            bus.sig[3] = ~bus.sig[3];
        end
        @(negedge clk);
        check("t5_ovf_set", bus.ovf, 1);
        check("t5_q_empty_paused", exp_q.size(), 0);
        push_wr(3, 32'd15);
        bus.pausa = 1'b0;
        wait_cycles(8);
        check("t5_mem3", mem[3], 15);
        check("t5_ovf_sticky", bus.ovf, 1);
        check("t5_bus_libre_off", bus.bus_libre, 0);

        // T6: pausa raised during RD; the commit finishes, RD toggle kept
        do_reset();
        @(negedge clk);
        push_wr(1, 32'd1);
        bus.sig[1] = ~bus.sig[1];
        wait_cycles(2);
        check("t6_state_rd", bus.state_dbg, 2);
        bus.pausa  = 1'b1;
        bus.sig[1] = ~bus.sig[1];
        wait_cycles(2);
        check("t6_bus_libre", bus.bus_libre, 1);
        wait_cycles(5);
        check("t6_bus_libre_hold", bus.bus_libre, 1);
        check("t6_mem1_first", mem[1], 1);
        check("t6_q_empty_paused", exp_q.size(), 0);
        push_wr(1, 32'd2);
        bus.pausa = 1'b0;
        wait_cycles(8);
        check("t6_mem1_final", mem[1], 2);
        check("t6_bus_libre_off", bus.bus_libre, 0);

        // T7: toggles with en=0 are ignored
        bus.en = 1'b0;
        @(negedge clk); bus.sig[2] = ~bus.sig[2];
        @(negedge clk); bus.sig[2] = ~bus.sig[2];
        wait_cycles(8);
        check("t7_mem2", mem[2], 0);
        check("t7_q_empty", exp_q.size(), 0);

        check("final_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
